// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: main FSM state encodings, opcode classes
// and datapath select codes.
package cpu_pkg;

   localparam int unsigned STATE_ENC_W = 4;
   localparam int unsigned OP_W        = 2;
   localparam int unsigned FUNCT_W     = 6;
   localparam int unsigned SEL_W       = 2;

   typedef enum logic [STATE_ENC_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNDEF    = 4'd10
   } statetype;

   localparam logic [OP_W-1:0] OP_DP  = 2'b00;
   localparam logic [OP_W-1:0] OP_MEM = 2'b01;
   localparam logic [OP_W-1:0] OP_BR  = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// Multicycle main control FSM (Moore). Define MAINFSM_UNDEF_TRAP_EN to trap
// Op=11 in a sticky UNDEF state; otherwise Op=11 retires as a 2-cycle NOP.
module mainfsm
   import cpu_pkg::*;
#(
   parameter int unsigned STATE_W = 4
) (
   input  logic               iClk,
   input  logic               iReset,
   input  logic [1:0]         iOp,
   input  logic [5:0]         iFunct,
   output logic               oIRWrite,
   output logic               oAdrSrc,
   output logic               oALUSrcA,
   output logic [1:0]         oALUSrcB,
   output logic [1:0]         oResultSrc,
   output logic               oALUOp,
   output logic               oNextPC,
   output logic               oRegW,
   output logic               oMemW,
   output logic               oBranch,
   output logic               oUndef,
   output logic [STATE_W-1:0] oState
);

   localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(FETCH);
   localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(DECODE);
   localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(MEMADR);
   localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(MEMREAD);
   localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(MEMWB);
   localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(MEMWRITE);
   localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(EXECUTER);
   localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(EXECUTEI);
   localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(ALUWB);
   localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(BRANCH);
`ifdef MAINFSM_UNDEF_TRAP_EN
   localparam logic [STATE_W-1:0] S_UNDEF    = STATE_W'(UNDEF);
`endif

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next_state;
   logic               w_funct_unused;

   // Funct[4:1] belong to the ALU decoder, not to sequencing.
   assign w_funct_unused = ^iFunct[4:1];

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) r_state <= S_FETCH;
      else         r_state <= w_next_state;
   end

   // Next state; iOp/iFunct only matter in DECODE and MEMADR.
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH:    w_next_state = S_DECODE;
         S_DECODE: begin
            case (iOp)
               OP_MEM:  w_next_state = S_MEMADR;
               OP_DP:   w_next_state = iFunct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   w_next_state = S_BRANCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
               default: w_next_state = S_UNDEF;
`else
               default: w_next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   w_next_state = iFunct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next_state = S_MEMWB;
         S_MEMWB:    w_next_state = S_FETCH;
         S_MEMWRITE: w_next_state = S_FETCH;
         S_EXECUTER: w_next_state = S_ALUWB;
         S_EXECUTEI: w_next_state = S_ALUWB;
         S_ALUWB:    w_next_state = S_FETCH;
         S_BRANCH:   w_next_state = S_FETCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
         S_UNDEF:    w_next_state = S_UNDEF;
`endif
         default:    w_next_state = S_FETCH;
      endcase
   end

   // Moore outputs; illegal encodings fall to the all-zero defaults.
   always_comb begin
      oIRWrite   = 1'b0;
      oAdrSrc    = 1'b0;
      oALUSrcA   = 1'b0;
      oALUSrcB   = SRCB_REG;
      oResultSrc = RES_ALUOUT;
      oALUOp     = 1'b0;
      oNextPC    = 1'b0;
      oRegW      = 1'b0;
      oMemW      = 1'b0;
      oBranch    = 1'b0;
      oUndef     = 1'b0;
      case (r_state)
         S_FETCH: begin
            oIRWrite   = 1'b1;
            oALUSrcA   = 1'b1;
            oALUSrcB   = SRCB_FOUR;
            oResultSrc = RES_ALU;
            oNextPC    = 1'b1;
         end
         S_DECODE: begin
            oALUSrcA   = 1'b1;
            oALUSrcB   = SRCB_FOUR;
            oResultSrc = RES_ALU;
         end
         S_MEMADR: begin
            oALUSrcB   = SRCB_IMM;
         end
         S_MEMREAD: begin
            oAdrSrc    = 1'b1;
         end
         S_MEMWRITE: begin
            oAdrSrc    = 1'b1;
            oMemW      = 1'b1;
         end
         S_MEMWB: begin
            oResultSrc = RES_DATA;
            oRegW      = 1'b1;
         end
         S_EXECUTER: begin
            oALUSrcB   = SRCB_REG;
            oALUOp     = 1'b1;
         end
         S_EXECUTEI: begin
            oALUSrcB   = SRCB_IMM;
            oALUOp     = 1'b1;
         end
         S_ALUWB: begin
            oRegW      = 1'b1;
         end
         S_BRANCH: begin
            oALUSrcB   = SRCB_IMM;
            oResultSrc = RES_ALU;
            oBranch    = 1'b1;
         end
`ifdef MAINFSM_UNDEF_TRAP_EN
         S_UNDEF: begin
            oUndef     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign oState = r_state;

endmodule
